// File: rtl/v_lane_pkg.sv
// Shared definitions for the vector lane writeback path.
//   DATA_W / NUM_GRP / VREG_AW : result group width, max groups, vreg address width
//   LMUL_*                     : lmul group-count codes
//   wb_state_t                 : writeback FSM states
//   ngrp_of / last_idx_of      : lmul code -> group count / index of final group
package v_lane_pkg;

   localparam int unsigned DATA_W  = 128;
   localparam int unsigned NUM_GRP = 4;
   localparam int unsigned VREG_AW = 5;

   localparam logic [2:0] LMUL_1 = 3'd0;
   localparam logic [2:0] LMUL_2 = 3'd1;
   localparam logic [2:0] LMUL_4 = 3'd2;

   typedef enum logic {IDLE, DRAIN} wb_state_t;

   // Codes above LMUL_4 are treated as four groups.
   function automatic logic [2:0] ngrp_of(logic [2:0] lmul);
      logic [2:0] n;
      case (lmul)
         LMUL_1:  n = 3'd1;
         LMUL_2:  n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] last_idx_of(logic [2:0] lmul);
      return 2'(ngrp_of(lmul) - 3'd1);
   endfunction

endpackage

// File: rtl/v_lane_wb_buf.sv
// Four-entry result group holding buffer with registered read port.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture all four groups from ld_data (entry 0 = group 1)
//   rd_en     : 0 forces the registered read data to zero
//   rd_idx    : entry to present on rd_data after the next edge
//   rd_data   : registered read data
// On a load edge the read register takes the incoming group directly so the
// first group is visible one cycle after capture.
module v_lane_wb_buf
   import v_lane_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic [NUM_GRP-1:0][DATA_W-1:0]   ld_data,
   input  logic                             rd_en,
   input  logic [1:0]                       rd_idx,
   output logic [DATA_W-1:0]                rd_data
);

   logic [NUM_GRP-1:0][DATA_W-1:0] mem_q;
   logic [DATA_W-1:0]              rd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
         rd_q  <= '0;
      end else begin
         if (load) begin
            mem_q <= ld_data;
         end
         if (!rd_en) begin
            rd_q <= '0;
         end else if (load) begin
            rd_q <= ld_data[rd_idx];
         end else begin
            rd_q <= mem_q[rd_idx];
         end
      end
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/v_lane_wb.sv
// Writeback collector between the vector lane array and the vreg file.
//   clk, nrst              : clock, asynchronous active-high reset
//   lanes_done             : completion pulse; lmul, sel_mul, vd_addr sampled with it
//   res_valu_1..4          : ALU result groups
//   res_vmul_1..4          : MUL result groups
//   wb_valid/wb_ready      : write handshake; wb_addr, wb_data, wb_last describe the group
//   busy                   : buffer holds undrained data
//   drop_err               : one-cycle pulse when a completion could not be accepted
// All outputs are registered; next-state values for address, last flag and
// read index are computed from the post-edge state so they line up with the FSM.
module v_lane_wb
   import v_lane_pkg::*;
(
   input  logic               clk,
   input  logic               nrst,
   input  logic               lanes_done,
   input  logic [2:0]         lmul,
   input  logic               sel_mul,
   input  logic [VREG_AW-1:0] vd_addr,
   input  logic [DATA_W-1:0]  res_valu_1,
   input  logic [DATA_W-1:0]  res_valu_2,
   input  logic [DATA_W-1:0]  res_valu_3,
   input  logic [DATA_W-1:0]  res_valu_4,
   input  logic [DATA_W-1:0]  res_vmul_1,
   input  logic [DATA_W-1:0]  res_vmul_2,
   input  logic [DATA_W-1:0]  res_vmul_3,
   input  logic [DATA_W-1:0]  res_vmul_4,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [VREG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               wb_last,
   output logic               busy,
   output logic               drop_err
);

   wb_state_t          state_q, state_d;
   logic [1:0]         k_q, k_d;
   logic [1:0]         last_idx_q, last_idx_d;
   logic [VREG_AW-1:0] base_q, base_d;
   logic [VREG_AW-1:0] addr_q, addr_d;
   logic               last_q, last_d;
   logic               drop_q, drop_d;

   logic xfer, final_xfer, accept;
   logic [NUM_GRP-1:0][DATA_W-1:0] ld_data;

   assign ld_data = sel_mul ? {res_vmul_4, res_vmul_3, res_vmul_2, res_vmul_1}
                            : {res_valu_4, res_valu_3, res_valu_2, res_valu_1};

   always_comb begin
      xfer       = (state_q == DRAIN) && wb_ready;
      final_xfer = xfer && last_q;
      // A new operation fits only when the buffer is empty or frees this cycle.
      accept     = lanes_done && ((state_q == IDLE) || final_xfer);

      state_d    = state_q;
      k_d        = k_q;
      last_idx_d = last_idx_q;
      base_d     = base_q;
      drop_d     = lanes_done && !accept;

      if (accept) begin
         state_d    = DRAIN;
         k_d        = 2'd0;
         last_idx_d = last_idx_of(lmul);
         base_d     = vd_addr;
      end else if (final_xfer) begin
         state_d = IDLE;
         k_d     = 2'd0;
      end else if (xfer) begin
         k_d = k_q + 2'd1;
      end

      // Address wraps naturally in VREG_AW bits.
      addr_d = (state_d == DRAIN) ? base_d + VREG_AW'(k_d) : '0;
      last_d = (state_d == DRAIN) && (k_d == last_idx_d);
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_q    <= IDLE;
         k_q        <= 2'd0;
         last_idx_q <= 2'd0;
         base_q     <= '0;
         addr_q     <= '0;
         last_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         last_idx_q <= last_idx_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         last_q     <= last_d;
         drop_q     <= drop_d;
      end
   end

   v_lane_wb_buf u_buf (
      .clk     (clk),
      .rst     (nrst),
      .load    (accept),
      .ld_data (ld_data),
      .rd_en   (state_d == DRAIN),
      .rd_idx  (k_d),
      .rd_data (wb_data)
   );

   assign wb_valid = (state_q == DRAIN);
   assign busy     = (state_q == DRAIN);
   assign wb_addr  = addr_q;
   assign wb_last  = last_q;
   assign drop_err = drop_q;

endmodule

// File: tb/tb_v_lane_wb.sv
// Directed bench for v_lane_wb: a vector table of per-cycle inputs and the
// outputs expected after that cycle's rising edge, plus a reset-mid-drain sequence.
module tb_v_lane_wb;

   logic         clk = 1'b0;
   logic         nrst;
   logic         lanes_done;
   logic [2:0]   lmul;
   logic         sel_mul;
   logic [4:0]   vd_addr;
   logic [7:0]   va, vm;
   logic         wb_valid, wb_ready, wb_last, busy, drop_err;
   logic [4:0]   wb_addr;
   logic [127:0] wb_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Every 32-bit lane of a group carries the same recognisable tag byte.
   function automatic logic [127:0] mk(logic [7:0] t);
      return {4{24'h5A5A5A, t}};
   endfunction

   v_lane_wb dut (
      .clk        (clk),
      .nrst       (nrst),
      .lanes_done (lanes_done),
      .lmul       (lmul),
      .sel_mul    (sel_mul),
      .vd_addr    (vd_addr),
      .res_valu_1 (mk(va + 8'd1)),
      .res_valu_2 (mk(va + 8'd2)),
      .res_valu_3 (mk(va + 8'd3)),
      .res_valu_4 (mk(va + 8'd4)),
      .res_vmul_1 (mk(vm + 8'd1)),
      .res_vmul_2 (mk(vm + 8'd2)),
      .res_vmul_3 (mk(vm + 8'd3)),
      .res_vmul_4 (mk(vm + 8'd4)),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_last    (wb_last),
      .busy       (busy),
      .drop_err   (drop_err)
   );

   typedef struct {
      logic       ld;
      logic [2:0] lmul;
      logic       sel;
      logic [4:0] vd;
      logic [7:0] va;
      logic [7:0] vm;
      logic       rdy;
      logic       ev;
      logic [4:0] ea;
      logic [7:0] et;   // expected data tag, 0 = all-zero data
      logic       el;
      logic       eb;
      logic       ed;
   } vec_t;

   localparam int NV = 29;
   vec_t vt[NV];

   function automatic vec_t mv(logic ld, logic [2:0] lm, logic sel, logic [4:0] vd,
                               logic [7:0] a, logic [7:0] m, logic rdy, logic ev,
                               logic [4:0] ea, logic [7:0] et, logic el, logic eb,
                               logic ed);
      vec_t v;
      v.ld = ld; v.lmul = lm; v.sel = sel; v.vd = vd; v.va = a; v.vm = m; v.rdy = rdy;
      v.ev = ev; v.ea = ea; v.et = et; v.el = el; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [4:0] ea,
                          input logic [7:0] et, input logic el, input logic eb,
                          input logic ed);
      chk({tag, " wb_valid"}, 128'(wb_valid), 128'(ev));
      chk({tag, " wb_addr"},  128'(wb_addr),  128'(ea));
      chk({tag, " wb_data"},  wb_data, (et == 8'h00) ? 128'h0 : mk(et));
      chk({tag, " wb_last"},  128'(wb_last),  128'(el));
      chk({tag, " busy"},     128'(busy),     128'(eb));
      chk({tag, " drop_err"}, 128'(drop_err), 128'(ed));
   endtask

   initial begin
      //          ld lm   sel vd     va     vm     rdy  ev ea     et     el eb ed
      // idle
      vt[0]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);
      // single group, ALU set chosen over MUL set
      vt[1]  = mv(1, 3'd0, 0, 5'd3,  8'hA0, 8'hB0, 1,   1, 5'd3,  8'hA1, 1, 1, 0);
      vt[2]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);
      // four MUL groups, address wraps 30,31,0,1
      vt[3]  = mv(1, 3'd2, 1, 5'd30, 8'hA0, 8'hB0, 1,   1, 5'd30, 8'hB1, 0, 1, 0);
      vt[4]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd31, 8'hB2, 0, 1, 0);
      vt[5]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd0,  8'hB3, 0, 1, 0);
      vt[6]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd1,  8'hB4, 1, 1, 0);
      vt[7]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);
      // backpressure: three stalled cycles, then two transfers
      vt[8]  = mv(1, 3'd1, 0, 5'd5,  8'hA0, 8'hB0, 0,   1, 5'd5,  8'hA1, 0, 1, 0);
      vt[9]  = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 0,   1, 5'd5,  8'hA1, 0, 1, 0);
      vt[10] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 0,   1, 5'd5,  8'hA1, 0, 1, 0);
      vt[11] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 0,   1, 5'd5,  8'hA1, 0, 1, 0);
      vt[12] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd6,  8'hA2, 1, 1, 0);
      vt[13] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);
      // back-to-back: new op accepted on the final transfer
      vt[14] = mv(1, 3'd1, 0, 5'd8,  8'hA0, 8'hB0, 1,   1, 5'd8,  8'hA1, 0, 1, 0);
      vt[15] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd9,  8'hA2, 1, 1, 0);
      vt[16] = mv(1, 3'd0, 1, 5'd20, 8'hA0, 8'hC0, 1,   1, 5'd20, 8'hC1, 1, 1, 0);
      vt[17] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);
      // overrun mid-drain and on a stalled last group; original data survives
      vt[18] = mv(1, 3'd2, 0, 5'd10, 8'hA0, 8'hB0, 1,   1, 5'd10, 8'hA1, 0, 1, 0);
      vt[19] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd11, 8'hA2, 0, 1, 0);
      vt[20] = mv(1, 3'd0, 0, 5'd2,  8'hD0, 8'hD0, 1,   1, 5'd12, 8'hA3, 0, 1, 1);
      vt[21] = mv(0, 3'd0, 0, 5'd0,  8'hD0, 8'hD0, 1,   1, 5'd13, 8'hA4, 1, 1, 0);
      vt[22] = mv(1, 3'd0, 0, 5'd7,  8'hE0, 8'hE0, 0,   1, 5'd13, 8'hA4, 1, 1, 1);
      vt[23] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);
      // lmul code 5 decodes to four groups
      vt[24] = mv(1, 3'd5, 1, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd0,  8'hB1, 0, 1, 0);
      vt[25] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd1,  8'hB2, 0, 1, 0);
      vt[26] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd2,  8'hB3, 0, 1, 0);
      vt[27] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   1, 5'd3,  8'hB4, 1, 1, 0);
      vt[28] = mv(0, 3'd0, 0, 5'd0,  8'hA0, 8'hB0, 1,   0, 5'd0,  8'h00, 0, 0, 0);

      nrst = 1'b1; lanes_done = 1'b0; lmul = 3'd0; sel_mul = 1'b0; vd_addr = 5'd0;
      va = 8'hA0; vm = 8'hB0; wb_ready = 1'b1;
      #1;
      chk_all("reset", 0, 5'd0, 8'h00, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 nrst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         lanes_done = vt[i].ld; lmul = vt[i].lmul; sel_mul = vt[i].sel;
         vd_addr = vt[i].vd; va = vt[i].va; vm = vt[i].vm; wb_ready = vt[i].rdy;
         @(posedge clk); #1;
         chk_all($sformatf("row%0d", i), vt[i].ev, vt[i].ea, vt[i].et, vt[i].el,
                 vt[i].eb, vt[i].ed);
      end

      // Reset during group 2 of 4 abandons the write at once.
      lanes_done = 1'b1; lmul = 3'd2; sel_mul = 1'b0; vd_addr = 5'd16;
      va = 8'hA0; wb_ready = 1'b1;
      @(posedge clk); #1;
      lanes_done = 1'b0;
      @(posedge clk); #1;
      chk_all("pre_rst", 1, 5'd17, 8'hA2, 0, 1, 0);
      nrst = 1'b1;
      #1;
      chk_all("mid_rst", 0, 5'd0, 8'h00, 0, 0, 0);
      @(posedge clk); #1;
      nrst = 1'b0;
      chk_all("rst_hold", 0, 5'd0, 8'h00, 0, 0, 0);
      lanes_done = 1'b1; lmul = 3'd0; sel_mul = 1'b0; vd_addr = 5'd3;
      @(posedge clk); #1;
      lanes_done = 1'b0;
      chk_all("post_rst", 1, 5'd3, 8'hA1, 1, 1, 0);
      @(posedge clk); #1;
      chk_all("post_rst_idle", 0, 5'd0, 8'h00, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
